// File: rtl/control_unit.sv
// control_unit: multi-cycle accumulator CPU controller.
// Each instruction walks FETCH -> DECODE -> EXECUTE. HLT parks the machine in
// HALT until reset. The accumulator doubles as the data-memory write data.
module control_unit #(
    parameter logic [3:0] RESET_PC = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    output logic [3:0] pc,
    output logic [3:0] address,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] acc,
    input  logic [7:0] data,
    output logic       zero,
    output logic       carry,
    output logic       halted
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] acc_q, acc_d;
    logic       carry_q, carry_d;

    logic [3:0] opcode;
    logic [3:0] operand;

    assign opcode  = ir_q[7:4];
    assign operand = ir_q[3:0];

    // Architectural registers; reset wins over every state, HALT included.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            acc_q   <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    // Next-state and datapath updates; everything holds unless a state changes it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        case (state_q)
            FETCH: begin
                ir_d    = instr;
                pc_d    = pc_q + 4'd1;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = EXECUTE;
            end
            EXECUTE: begin
                state_d = FETCH;
                case (opcode)
                    OP_LDA: acc_d = data;
                    OP_ADD: {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, data};
                    OP_SUB: begin
                        acc_d   = acc_q - data;
                        carry_d = (acc_q < data);
                    end
                    OP_AND: acc_d = acc_q & data;
                    OP_OR:  acc_d = acc_q | data;
                    OP_JMP: pc_d = operand;
                    OP_JZ: begin
                        if (acc_q == 8'd0) begin
                            pc_d = operand;
                        end
                    end
                    OP_LDI: acc_d = {4'b0000, operand};
                    OP_HLT: state_d = HALT;
                    default: begin
                    end
                endcase
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Memory strobes; a write is suppressed in any cycle where reset is asserted.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (state_q == EXECUTE) begin
            mem_read  = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB)
                     || (opcode == OP_AND) || (opcode == OP_OR);
            mem_write = (opcode == OP_STA) && !reset;
        end
    end

    assign pc      = pc_q;
    assign address = operand;
    assign acc     = acc_q;
    assign zero    = (acc_q == 8'd0);
    assign carry   = carry_q;
    assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed programs with hand-computed results.
// Samples are taken on the falling edge; "cycle 1" is the first FETCH after reset.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] instr;
    logic [3:0] pc;
    logic [3:0] address;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] acc;
    logic [7:0] data;
    logic       zero;
    logic       carry;
    logic       halted;

    logic [7:0] prog [16];
    logic [7:0] ram  [16];
    logic       ramInitReq = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    control_unit #(.RESET_PC(4'd0)) dut (
        .clk(clk), .reset(reset), .instr(instr), .pc(pc), .address(address),
        .mem_read(mem_read), .mem_write(mem_write), .acc(acc), .data(data),
        .zero(zero), .carry(carry), .halted(halted)
    );

    always #5 clk = ~clk;

    // Program memory and data memory read ports are combinational.
    assign instr = prog[pc];
    assign data  = ram[address];

    // Data memory: preload ram[i]=i on request, otherwise accept CPU writes.
    always @(posedge clk) begin
        if (ramInitReq) begin
            for (int i = 0; i < 16; i++) ram[i] <= (i < 10) ? 8'(i) : 8'h00;
        end else if (mem_write) begin
            ram[address] <= acc;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clearProgram();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    // One reset edge, with the data memory reloaded; returns sampling cycle 1.
    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        ramInitReq = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ramInitReq = 1'b0;
    endtask

    task automatic test_reset();
        clearProgram();
        doReset();
        compared++; if (pc !== 4'd0) begin mismatched++; $display("FAIL reset_pc: got %0h want 0", pc); end
        compared++; if (acc !== 8'h00) begin mismatched++; $display("FAIL reset_acc: got %0h want 00", acc); end
        compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL reset_halted: got %b want 0", halted); end
        compared++; if (zero !== 1'b1) begin mismatched++; $display("FAIL reset_zero: got %b want 1", zero); end
        compared++; if (carry !== 1'b0) begin mismatched++; $display("FAIL reset_carry: got %b want 0", carry); end
        compared++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            mismatched++; $display("FAIL reset_mem: got rd=%b wr=%b want 0 0", mem_read, mem_write);
        end
    endtask

    task automatic test_lda_add_sta();
        clearProgram();
        prog[0] = 8'h13; prog[1] = 8'h34; prog[2] = 8'h2A; prog[3] = 8'hF0;
        doReset();
        tick();
        compared++; if (pc !== 4'd1 || mem_read !== 1'b0) begin
            mismatched++; $display("FAIL decode_quiet: got pc=%0h rd=%b want 1 0", pc, mem_read);
        end
        tick();
        compared++; if (mem_read !== 1'b1 || address !== 4'd3) begin
            mismatched++; $display("FAIL lda_read: got rd=%b addr=%0h want 1 3", mem_read, address);
        end
        repeat (6) tick();
        compared++; if (mem_write !== 1'b1 || address !== 4'd10 || acc !== 8'd7) begin
            mismatched++; $display("FAIL sta_cycle9: got wr=%b addr=%0h acc=%0h want 1 a 07", mem_write, address, acc);
        end
        repeat (3) tick();
        compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL halt_early: got %b want 0", halted); end
        tick();
        compared++; if (halted !== 1'b1 || pc !== 4'd4) begin
            mismatched++; $display("FAIL halt_cycle13: got halted=%b pc=%0h want 1 4", halted, pc);
        end
        compared++; if (acc !== 8'd7 || carry !== 1'b0) begin
            mismatched++; $display("FAIL add_result: got acc=%0h c=%b want 07 0", acc, carry);
        end
        compared++; if (ram[10] !== 8'd7) begin mismatched++; $display("FAIL ram10: got %0h want 07", ram[10]); end
        repeat (4) tick();
        compared++; if (halted !== 1'b1 || pc !== 4'd4 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            mismatched++; $display("FAIL halt_hold: got h=%b pc=%0h rd=%b wr=%b want 1 4 0 0", halted, pc, mem_read, mem_write);
        end
    endtask

    task automatic test_arith();
        clearProgram();
        prog[0] = 8'h9F; prog[1] = 8'h39; prog[2] = 8'h24; prog[3] = 8'hF0;
        doReset();
        repeat (3) tick();
        compared++; if (acc !== 8'h0F) begin mismatched++; $display("FAIL ldi_f: got %0h want 0f", acc); end
        repeat (3) tick();
        compared++; if (acc !== 8'h18 || carry !== 1'b0) begin
            mismatched++; $display("FAIL add_9: got acc=%0h c=%b want 18 0", acc, carry);
        end
        clearProgram();
        prog[0] = 8'h90; prog[1] = 8'h41; prog[2] = 8'h31; prog[3] = 8'h9A; prog[4] = 8'hF0;
        doReset();
        repeat (6) tick();
        compared++; if (acc !== 8'hFF || carry !== 1'b1 || zero !== 1'b0) begin
            mismatched++; $display("FAIL sub_borrow: got acc=%0h c=%b z=%b want ff 1 0", acc, carry, zero);
        end
        repeat (3) tick();
        compared++; if (acc !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
            mismatched++; $display("FAIL add_wrap: got acc=%0h c=%b z=%b want 00 1 1", acc, carry, zero);
        end
        repeat (3) tick();
        compared++; if (acc !== 8'h0A || carry !== 1'b1) begin
            mismatched++; $display("FAIL ldi_keeps_carry: got acc=%0h c=%b want 0a 1", acc, carry);
        end
    endtask

    task automatic test_jz();
        clearProgram();
        prog[0] = 8'h90; prog[1] = 8'h83; prog[2] = 8'h9A; prog[3] = 8'hF0;
        doReset();
        repeat (9) tick();
        compared++; if (halted !== 1'b1 || acc !== 8'h00 || pc !== 4'd4) begin
            mismatched++; $display("FAIL jz_taken: got h=%b acc=%0h pc=%0h want 1 00 4", halted, acc, pc);
        end
        prog[0] = 8'h91;
        doReset();
        repeat (9) tick();
        compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL jz_not_taken_early: got %b want 0", halted); end
        repeat (3) tick();
        compared++; if (halted !== 1'b1 || acc !== 8'h0A || pc !== 4'd4) begin
            mismatched++; $display("FAIL jz_not_taken: got h=%b acc=%0h pc=%0h want 1 0a 4", halted, acc, pc);
        end
        prog[0] = 8'h90; prog[1] = 8'h82;
        doReset();
        repeat (12) tick();
        compared++; if (halted !== 1'b1 || acc !== 8'h0A || pc !== 4'd4) begin
            mismatched++; $display("FAIL jz_fallthrough: got h=%b acc=%0h pc=%0h want 1 0a 4", halted, acc, pc);
        end
    endtask

    task automatic test_logic_jmp();
        clearProgram();
        prog[0] = 8'h9C; prog[1] = 8'h63; prog[2] = 8'h55; prog[3] = 8'h76;
        prog[4] = 8'h9E; prog[5] = 8'h9E; prog[6] = 8'hA0; prog[7] = 8'hF0;
        doReset();
        repeat (6) tick();
        compared++; if (acc !== 8'h0F) begin mismatched++; $display("FAIL or_3: got %0h want 0f", acc); end
        repeat (3) tick();
        compared++; if (acc !== 8'h05) begin mismatched++; $display("FAIL and_5: got %0h want 05", acc); end
        repeat (3) tick();
        compared++; if (pc !== 4'd6) begin mismatched++; $display("FAIL jmp_6: got %0h want 6", pc); end
        repeat (6) tick();
        compared++; if (halted !== 1'b1 || acc !== 8'h05 || pc !== 4'd8 || carry !== 1'b0) begin
            mismatched++; $display("FAIL jmp_halt: got h=%b acc=%0h pc=%0h c=%b want 1 05 8 0", halted, acc, pc, carry);
        end
    endtask

    task automatic test_reset_in_halt();
        prog[8] = 8'h9F;
        repeat (3) tick();
        compared++; if (halted !== 1'b1 || pc !== 4'd8 || acc !== 8'h05) begin
            mismatched++; $display("FAIL halt_ignores_instr: got h=%b pc=%0h acc=%0h want 1 8 05", halted, pc, acc);
        end
        doReset();
        compared++; if (halted !== 1'b0 || pc !== 4'd0 || acc !== 8'h00) begin
            mismatched++; $display("FAIL halt_reset: got h=%b pc=%0h acc=%0h want 0 0 00", halted, pc, acc);
        end
        tick();
        compared++; if (pc !== 4'd1) begin mismatched++; $display("FAIL halt_reset_fetch: got %0h want 1", pc); end
    endtask

    task automatic test_reset_mid_sta();
        clearProgram();
        prog[0] = 8'h97; prog[1] = 8'h25; prog[2] = 8'hF0;
        doReset();
        repeat (5) tick();
        compared++; if (mem_write !== 1'b1 || address !== 4'd5 || acc !== 8'h07) begin
            mismatched++; $display("FAIL sta_before_reset: got wr=%b addr=%0h acc=%0h want 1 5 07", mem_write, address, acc);
        end
        reset = 1'b1;
        #1;
        compared++; if (mem_write !== 1'b0) begin mismatched++; $display("FAIL sta_reset_gate: got %b want 0", mem_write); end
        @(negedge clk);
        reset = 1'b0;
        compared++; if (pc !== 4'd0 || acc !== 8'h00 || halted !== 1'b0) begin
            mismatched++; $display("FAIL mid_reset_state: got pc=%0h acc=%0h h=%b want 0 00 0", pc, acc, halted);
        end
        compared++; if (ram[5] !== 8'd5) begin mismatched++; $display("FAIL ram5_kept: got %0h want 05", ram[5]); end
    endtask

    task automatic test_pc_wrap();
        logic [3:0] expPc;
        int strobeErrors;
        clearProgram();
        doReset();
        strobeErrors = 0;
        for (int k = 0; k <= 16; k++) begin
            expPc = 4'(k);
            compared++; if (pc !== expPc) begin
                mismatched++; $display("FAIL nop_pc_%0d: got %0h want %0h", k, pc, expPc);
            end
            for (int c = 0; c < 3; c++) begin
                if (mem_read !== 1'b0 || mem_write !== 1'b0) strobeErrors++;
                tick();
            end
        end
        compared++; if (strobeErrors !== 0) begin
            mismatched++; $display("FAIL nop_strobes: got %0d active cycles want 0", strobeErrors);
        end
    endtask

    initial begin
        $display("[TB] control_unit directed tests");
        test_reset();
        test_lda_add_sta();
        test_arith();
        test_jz();
        test_logic_jmp();
        test_reset_in_halt();
        test_reset_mid_sta();
        test_pc_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: RESET_PC, default 4'd0, program counter value loaded on reset.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: instr  input  8  instruction word from program memory at pc; [7:4] opcode, [3:0] operand.
REQ-005 Port: pc  output  4  program counter, registered.
REQ-006 Port: address  output  4  data-memory address; equals IR[3:0].
REQ-007 Port: mem_read  output  1  data-memory read enable.
REQ-008 Port: mem_write  output  1  data-memory write enable; the write occurs on the clk edge ending the cycle.
REQ-009 Port: acc  output  8  accumulator, registered; also the data-memory write data.
REQ-010 Port: data  input  8  data-memory read data, valid combinationally in the same cycle as mem_read and address.
REQ-011 Port: zero  output  1  combinational (acc == 8'd0).
REQ-012 Port: carry  output  1  registered carry/borrow flag.
REQ-013 Port: halted  output  1  high while in HALT.

Function
REQ-014 FSM states SHALL be FETCH, DECODE, EXECUTE and HALT; transitions FETCH->DECODE->EXECUTE->FETCH, except EXECUTE of HLT->HALT; HALT->HALT until reset.
REQ-015 FETCH SHALL load IR <= instr and set pc <= pc+1, modulo 16 (15 wraps to 0).
REQ-016 DECODE SHALL change no architectural state (pc, acc, carry); mem_read=0 and mem_write=0.
REQ-017 mem_read SHALL be 1 only in EXECUTE with opcode LDA, ADD, SUB, AND or OR.
REQ-018 mem_write SHALL be 1 only in EXECUTE with opcode STA, and SHALL be forced to 0 whenever reset=1.
REQ-019 Opcodes, executed at the edge ending EXECUTE: 0 NOP; 1 LDA acc<=data; 2 STA (memory write only, acc unchanged); 3 ADD {carry,acc}<=acc+data (9-bit); 4 SUB acc<=acc-data, carry<=1 iff acc<data (borrow); 5 AND acc<=acc&data; 6 OR acc<=acc|data; 7 JMP pc<=operand; 8 JZ pc<=operand iff zero=1, else no change; 9 LDI acc<={4'b0,operand}; F HLT.
REQ-020 Opcodes A-E SHALL execute as NOP.
REQ-021 carry SHALL change only on ADD and SUB; all other opcodes hold it.
REQ-022 Every instruction except HLT SHALL take exactly 3 cycles; HLT enters HALT after 3 cycles.
REQ-023 JZ SHALL sample zero from acc as it stands during EXECUTE, i.e. the result of the preceding instruction.
REQ-024 A jump to operand equal to the already-incremented pc SHALL behave as a fall-through.
REQ-025 In HALT: pc, acc, IR and carry SHALL hold; mem_read=0, mem_write=0, halted=1; instr is ignored.
REQ-026 pc wrap SHALL be silent: after the instruction at address 15, the next fetch is from 0.

Reset
REQ-027 While reset=1 at a clk edge: state<=FETCH, pc<=RESET_PC, IR<=8'h00, acc<=8'h00, carry<=0.
REQ-028 Reset SHALL take priority over every state, including mid-EXECUTE and HALT; an STA in EXECUTE during a reset cycle SHALL NOT write memory.
REQ-029 After reset: halted=0, zero=1, mem_read=0, mem_write=0; the first FETCH occurs in the cycle after reset deasserts.

Verification
(Data memory preloaded with ram[i]=i for i=0..9; program memory driven by the bench from pc.)
REQ-030 Program 0x13,0x34,0x2A,0xF0 (LDA 3, ADD 4, STA 10, HLT) -> acc=7, carry=0; mem_write=1 with address=10 and acc=7 in cycle 9 after reset; halted=1 from cycle 13 onward, pc=4.
REQ-031 Program 0x9F,0x39,0x24 -> acc=0x0F then 0x18; carry=0. Second case: LDI 0, SUB 1 -> acc=0xFF, carry=1, zero=0.
REQ-032 Program 0x90,0x83,0x9A,0xF0 (LDI 0, JZ 3, ...) -> jump taken, instruction at 2 skipped, acc=0 at HALT. Same program with LDI 1 first -> no jump, acc=0x0A.
REQ-033 Program of sixteen NOPs with the bench holding instr=0x00 -> pc sequence 0..15 then 0; mem_read and mem_write stay 0 throughout.
REQ-034 Reset asserted for one cycle while in EXECUTE of STA 5 -> mem_write=0 that cycle, ram[5] still 5, pc=0, acc=0 next cycle. Reset applied in HALT -> halted=0 next cycle and fetch resumes at pc=0.
